// File: rtl/ibex_id_sequencer.sv
// ibex_id_sequencer: holds each instruction in ID until it completes and sequences
// multi-cycle instructions, traps, redirects, WFI sleep and the retire counter.
`default_nettype none

module ibex_id_sequencer #(
  parameter int unsigned MinstretWidth = 32
) (
  input  logic                     clk,
  input  logic                     rst_ni,
  input  logic                     instr_valid_i,
  input  logic                     dec_illegal_i,
  input  logic                     dec_ecall_i,
  input  logic                     dec_ebrk_i,
  input  logic                     dec_mret_i,
  input  logic                     dec_wfi_i,
  input  logic                     dec_jump_set_i,
  input  logic                     dec_branch_in_dec_i,
  input  logic                     dec_mult_en_i,
  input  logic                     dec_div_en_i,
  input  logic                     dec_data_req_i,
  input  logic                     dec_csr_pipe_flush_i,
  input  logic                     branch_taken_i,
  input  logic                     md_ready_i,
  input  logic                     lsu_done_i,
  input  logic                     irq_pending_i,
  output logic                     instr_new_o,
  output logic                     instr_ack_o,
  output logic                     halt_if_o,
  output logic                     regfile_we_en_o,
  output logic                     md_en_o,
  output logic                     lsu_req_o,
  output logic                     pc_set_o,
  output logic [1:0]               pc_mux_o,
  output logic                     exc_req_o,
  output logic [1:0]               exc_cause_o,
  output logic                     instr_ret_o,
  output logic [MinstretWidth-1:0] minstret_o
);

  typedef enum logic [2:0] {
    DECODE   = 3'd0,
    SECOND   = 3'd1,
    MD_WAIT  = 3'd2,
    LSU_WAIT = 3'd3,
    SLEEP    = 3'd4
  } state_e;

  localparam logic [1:0] PC_JUMP = 2'd0;
  localparam logic [1:0] PC_EXC  = 2'd1;
  localparam logic [1:0] PC_MEPC = 2'd2;
  localparam logic [1:0] PC_NEXT = 2'd3;

  state_e                   state_q, state_d;
  logic                     second_branch_q, second_branch_d;
  logic [MinstretWidth-1:0] minstret_q;
  logic                     ack;
  logic                     sleeping;

  always_comb begin
    state_d         = state_q;
    second_branch_d = second_branch_q;
    instr_new_o     = 1'b0;
    ack             = 1'b0;
    regfile_we_en_o = 1'b0;
    md_en_o         = 1'b0;
    lsu_req_o       = 1'b0;
    pc_set_o        = 1'b0;
    pc_mux_o        = PC_JUMP;
    exc_req_o       = 1'b0;
    exc_cause_o     = 2'd0;
    instr_ret_o     = 1'b0;
    sleeping        = 1'b0;

    if (rst_ni) begin
      case (state_q)
        DECODE: begin
          if (instr_valid_i) begin
            instr_new_o = 1'b1;
            if (dec_illegal_i || dec_ebrk_i || dec_ecall_i) begin
              exc_req_o   = 1'b1;
              exc_cause_o = dec_illegal_i ? 2'd0 : (dec_ebrk_i ? 2'd2 : 2'd1);
              pc_set_o    = 1'b1;
              pc_mux_o    = PC_EXC;
              ack         = 1'b1;
            end else if (dec_mret_i) begin
              pc_set_o    = 1'b1;
              pc_mux_o    = PC_MEPC;
              ack         = 1'b1;
              instr_ret_o = 1'b1;
            end else if (dec_wfi_i) begin
              ack         = 1'b1;
              instr_ret_o = 1'b1;
              state_d     = SLEEP;
            end else if (dec_jump_set_i) begin
              pc_set_o        = 1'b1;
              pc_mux_o        = PC_JUMP;
              second_branch_d = 1'b0;
              state_d         = SECOND;
            end else if (dec_branch_in_dec_i) begin
              // Taken branches redirect in their second cycle, so one pc_set per instruction.
              if (branch_taken_i) begin
                second_branch_d = 1'b1;
                state_d         = SECOND;
              end else begin
                ack         = 1'b1;
                instr_ret_o = 1'b1;
              end
            end else if (dec_mult_en_i || dec_div_en_i) begin
              md_en_o = 1'b1;
              if (md_ready_i) begin
                ack             = 1'b1;
                regfile_we_en_o = 1'b1;
                instr_ret_o     = 1'b1;
              end else begin
                state_d = MD_WAIT;
              end
            end else if (dec_data_req_i) begin
              lsu_req_o = 1'b1;
              state_d   = LSU_WAIT;
            end else if (dec_csr_pipe_flush_i) begin
              regfile_we_en_o = 1'b1;
              pc_set_o        = 1'b1;
              pc_mux_o        = PC_NEXT;
              ack             = 1'b1;
              instr_ret_o     = 1'b1;
            end else begin
              regfile_we_en_o = 1'b1;
              ack             = 1'b1;
              instr_ret_o     = 1'b1;
            end
          end
        end
        SECOND: begin
          ack         = 1'b1;
          instr_ret_o = 1'b1;
          state_d     = DECODE;
          if (second_branch_q) begin
            pc_set_o = 1'b1;
            pc_mux_o = PC_JUMP;
          end else begin
            regfile_we_en_o = 1'b1;
          end
        end
        MD_WAIT: begin
          md_en_o = 1'b1;
          if (md_ready_i) begin
            ack             = 1'b1;
            regfile_we_en_o = 1'b1;
            instr_ret_o     = 1'b1;
            state_d         = DECODE;
          end
        end
        LSU_WAIT: begin
          if (lsu_done_i) begin
            ack             = 1'b1;
            regfile_we_en_o = 1'b1;
            instr_ret_o     = 1'b1;
            state_d         = DECODE;
          end
        end
        SLEEP: begin
          sleeping = 1'b1;
          if (irq_pending_i) begin
            state_d = DECODE;
          end
        end
        default: state_d = DECODE;
      endcase
    end

    instr_ack_o = ack;
    halt_if_o   = (rst_ni & instr_valid_i & ~ack) | sleeping;
  end

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      state_q         <= DECODE;
      second_branch_q <= 1'b0;
      minstret_q      <= '0;
    end else begin
      state_q         <= state_d;
      second_branch_q <= second_branch_d;
      if (instr_ret_o) begin
        minstret_q <= minstret_q + {{(MinstretWidth-1){1'b0}}, 1'b1};
      end
    end
  end

  assign minstret_o = minstret_q;

endmodule

`default_nettype wire

// File: tb/tb_ibex_id_sequencer.sv
// Bench for ibex_id_sequencer: directed table, hand sequences, then random stimulus
// against a per-instruction latency model.
`default_nettype none

module tb_ibex_id_sequencer;

  localparam int W = 4;

  typedef struct packed {
    logic valid, illegal, ecall, ebrk, mret, wfi, jump, branch;
    logic mult, div, req, flush, taken, mdready, lsudone, irq;
  } in_t;

  typedef struct packed {
    logic inew, ack, halt, we, md, lsu, pcset;
    logic [1:0] mux;
    logic exc;
    logic [1:0] cause;
    logic ret;
  } out_t;

  typedef struct {
    string name;
    in_t   in;
    out_t  exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_ni;
  logic instr_valid_i, dec_illegal_i, dec_ecall_i, dec_ebrk_i, dec_mret_i, dec_wfi_i;
  logic dec_jump_set_i, dec_branch_in_dec_i, dec_mult_en_i, dec_div_en_i;
  logic dec_data_req_i, dec_csr_pipe_flush_i, branch_taken_i, md_ready_i;
  logic lsu_done_i, irq_pending_i;
  logic instr_new_o, instr_ack_o, halt_if_o, regfile_we_en_o, md_en_o, lsu_req_o;
  logic pc_set_o, exc_req_o, instr_ret_o;
  logic [1:0] pc_mux_o, exc_cause_o;
  logic [W-1:0] minstret_o;

  int vectors = 0;
  int miscompares = 0;

  // Model: the instruction still in flight (0 none, 1 jump link, 2 taken branch,
  // 3 mult/div, 4 memory), whether the core is asleep, and the retire count.
  int          m_pending = 0, n_pending;
  bit          m_sleep = 0, n_sleep;
  int unsigned m_count = 0, n_count;

  ibex_id_sequencer #(.MinstretWidth(W)) dut (
    .clk(clk), .rst_ni(rst_ni), .instr_valid_i(instr_valid_i),
    .dec_illegal_i(dec_illegal_i), .dec_ecall_i(dec_ecall_i), .dec_ebrk_i(dec_ebrk_i),
    .dec_mret_i(dec_mret_i), .dec_wfi_i(dec_wfi_i), .dec_jump_set_i(dec_jump_set_i),
    .dec_branch_in_dec_i(dec_branch_in_dec_i), .dec_mult_en_i(dec_mult_en_i),
    .dec_div_en_i(dec_div_en_i), .dec_data_req_i(dec_data_req_i),
    .dec_csr_pipe_flush_i(dec_csr_pipe_flush_i), .branch_taken_i(branch_taken_i),
    .md_ready_i(md_ready_i), .lsu_done_i(lsu_done_i), .irq_pending_i(irq_pending_i),
    .instr_new_o(instr_new_o), .instr_ack_o(instr_ack_o), .halt_if_o(halt_if_o),
    .regfile_we_en_o(regfile_we_en_o), .md_en_o(md_en_o), .lsu_req_o(lsu_req_o),
    .pc_set_o(pc_set_o), .pc_mux_o(pc_mux_o), .exc_req_o(exc_req_o),
    .exc_cause_o(exc_cause_o), .instr_ret_o(instr_ret_o), .minstret_o(minstret_o)
  );

  always #5 clk = ~clk;

  function automatic out_t mk(input bit inew, ack, halt, we, md, lsu, pcset,
                              input logic [1:0] mux, input bit exc,
                              input logic [1:0] cause, input bit ret);
    out_t o;
    o = '{inew, ack, halt, we, md, lsu, pcset, mux, exc, cause, ret};
    return o;
  endfunction

  // Redirect source and cause are don't-care unless their strobe is high.
  function automatic out_t norm(input out_t o);
    out_t r = o;
    if (!r.pcset) r.mux = 2'd0;
    if (!r.exc) r.cause = 2'd0;
    return r;
  endfunction

  task automatic model_eval(input in_t in, input bit rstn, output out_t o);
    o = '0;
    n_pending = m_pending;
    n_sleep = m_sleep;
    n_count = m_count;
    if (!rstn) begin
      n_pending = 0;
      n_sleep = 0;
      n_count = 0;
      return;
    end
    if (m_sleep) begin
      o.halt = 1;
      if (in.irq) n_sleep = 0;
    end else if (m_pending != 0) begin
      case (m_pending)
        1: begin o.ack = 1; o.we = 1; o.ret = 1; n_pending = 0; end
        2: begin o.ack = 1; o.pcset = 1; o.mux = 0; o.ret = 1; n_pending = 0; end
        3: begin
          o.md = 1;
          if (in.mdready) begin o.ack = 1; o.we = 1; o.ret = 1; n_pending = 0; end
        end
        default: if (in.lsudone) begin o.ack = 1; o.we = 1; o.ret = 1; n_pending = 0; end
      endcase
    end else if (in.valid) begin
      o.inew = 1;
      if (in.illegal || in.ebrk || in.ecall) begin
        o.exc = 1; o.pcset = 1; o.mux = 1; o.ack = 1;
        o.cause = in.illegal ? 2'd0 : (in.ebrk ? 2'd2 : 2'd1);
      end else if (in.mret) begin
        o.pcset = 1; o.mux = 2; o.ack = 1; o.ret = 1;
      end else if (in.wfi) begin
        o.ack = 1; o.ret = 1; n_sleep = 1;
      end else if (in.jump) begin
        o.pcset = 1; o.mux = 0; n_pending = 1;
      end else if (in.branch) begin
        if (in.taken) n_pending = 2;
        else begin o.ack = 1; o.ret = 1; end
      end else if (in.mult || in.div) begin
        o.md = 1;
        if (in.mdready) begin o.ack = 1; o.we = 1; o.ret = 1; end
        else n_pending = 3;
      end else if (in.req) begin
        o.lsu = 1; n_pending = 4;
      end else if (in.flush) begin
        o.we = 1; o.pcset = 1; o.mux = 3; o.ack = 1; o.ret = 1;
      end else begin
        o.we = 1; o.ack = 1; o.ret = 1;
      end
    end
    o.halt = o.halt | (in.valid & ~o.ack);
    if (o.ret) n_count = (m_count + 1) % (1 << W);
  endtask

  // One clock: drive, compare at the falling edge, advance the model at the rising edge.
  task automatic cycle(input string name, input in_t in, input bit rstn,
                       input bit use_tab, input out_t tab);
    out_t m, act, exp;
    rst_ni = rstn;
    {instr_valid_i, dec_illegal_i, dec_ecall_i, dec_ebrk_i, dec_mret_i, dec_wfi_i,
     dec_jump_set_i, dec_branch_in_dec_i, dec_mult_en_i, dec_div_en_i, dec_data_req_i,
     dec_csr_pipe_flush_i, branch_taken_i, md_ready_i, lsu_done_i, irq_pending_i} = in;
    @(negedge clk);
    model_eval(in, rstn, m);
    exp = norm(use_tab ? tab : m);
    act = norm({instr_new_o, instr_ack_o, halt_if_o, regfile_we_en_o, md_en_o, lsu_req_o,
                pc_set_o, pc_mux_o, exc_req_o, exc_cause_o, instr_ret_o});
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s outputs: got %b want %b (new,ack,halt,we,md,lsu,pcset,mux,exc,cause,ret)",
               name, act, exp);
    end
    vectors++;
    if (minstret_o !== m_count[W-1:0]) begin
      miscompares++;
      $display("FAIL %s minstret: got %0d want %0d", name, minstret_o, m_count[W-1:0]);
    end
    @(posedge clk);
    m_pending = n_pending;
    m_sleep = n_sleep;
    m_count = n_count;
    #1;
  endtask

  task automatic chk_cnt(input string name, input logic [W-1:0] want);
    vectors++;
    if (minstret_o !== want) begin
      miscompares++;
      $display("FAIL %s: minstret got %0d want %0d", name, minstret_o, want);
    end
  endtask

  vec_t tab[$];
  in_t  v;
  out_t z = '0;

  initial begin
    // Single-cycle instructions from an idle DECODE.
    v = '0; v.valid = 1;                                  tab.push_back('{"alu", v, mk(1,1,0,1,0,0,0,0,0,0,1)});
    v = '0; v.valid = 1; v.illegal = 1; v.ecall = 1;      tab.push_back('{"ill+ecall", v, mk(1,1,0,0,0,0,1,1,1,0,0)});
    v = '0; v.valid = 1; v.ebrk = 1; v.ecall = 1;         tab.push_back('{"ebrk+ecall", v, mk(1,1,0,0,0,0,1,1,1,2,0)});
    v = '0; v.valid = 1; v.ecall = 1;                     tab.push_back('{"ecall", v, mk(1,1,0,0,0,0,1,1,1,1,0)});
    v = '0; v.valid = 1; v.mret = 1; v.wfi = 1;           tab.push_back('{"mret", v, mk(1,1,0,0,0,0,1,2,0,0,1)});
    v = '0; v.valid = 1; v.flush = 1;                     tab.push_back('{"flush", v, mk(1,1,0,1,0,0,1,3,0,0,1)});
    v = '0; v.valid = 1; v.branch = 1;                    tab.push_back('{"br_nt", v, mk(1,1,0,0,0,0,0,0,0,0,1)});
    v = '0; v.valid = 1; v.mult = 1; v.mdready = 1;       tab.push_back('{"mul_rdy", v, mk(1,1,0,1,1,0,0,0,0,0,1)});
    v = '0; v.valid = 1; v.div = 1; v.req = 1; v.mdready = 1; tab.push_back('{"div_rdy", v, mk(1,1,0,1,1,0,0,0,0,0,1)});
    v = '0; v.valid = 1; v.illegal = 1; v.mret = 1; v.jump = 1; tab.push_back('{"ill_prio", v, mk(1,1,0,0,0,0,1,1,1,0,0)});
    v = '0; v.lsudone = 1; v.mdready = 1;                 tab.push_back('{"idle", v, z});

    // Reset with a valid ALU instruction presented.
    v = '0; v.valid = 1;
    cycle("reset0", v, 1'b0, 1, z);
    cycle("reset1", v, 1'b0, 1, z);
    chk_cnt("reset_cnt", 0);
    cycle("post_reset_alu", v, 1'b1, 1, mk(1,1,0,1,0,0,0,0,0,0,1));
    chk_cnt("post_reset_cnt", 1);

    foreach (tab[i]) cycle(tab[i].name, tab[i].in, 1'b1, 1, tab[i].exp);

    // JAL: redirect in cycle 1, link write in cycle 2.
    v = '0; v.valid = 1; v.jump = 1;
    cycle("jal_c1", v, 1'b1, 1, mk(1,0,1,0,0,0,1,0,0,0,0));
    cycle("jal_c2", v, 1'b1, 1, mk(0,1,0,1,0,0,0,0,0,0,1));

    // Taken branch: redirect and ack in cycle 2, no write.
    v = '0; v.valid = 1; v.branch = 1; v.taken = 1;
    cycle("br_t_c1", v, 1'b1, 1, mk(1,0,1,0,0,0,0,0,0,0,0));
    v.taken = 0;
    cycle("br_t_c2", v, 1'b1, 1, mk(0,1,0,0,0,0,1,0,0,0,1));

    // DIV with md_ready in cycle 5.
    v = '0; v.valid = 1; v.div = 1;
    cycle("div_c1", v, 1'b1, 1, mk(1,0,1,0,1,0,0,0,0,0,0));
    for (int c = 2; c <= 4; c++) cycle($sformatf("div_c%0d", c), v, 1'b1, 1, mk(0,0,1,0,1,0,0,0,0,0,0));
    v.mdready = 1;
    cycle("div_c5", v, 1'b1, 1, mk(0,1,0,1,1,0,0,0,0,0,1));

    // Load: done in the request cycle is ignored.
    v = '0; v.valid = 1; v.req = 1; v.lsudone = 1;
    cycle("lsu_c1", v, 1'b1, 1, mk(1,0,1,0,0,1,0,0,0,0,0));
    v.lsudone = 0;
    cycle("lsu_c2", v, 1'b1, 1, mk(0,0,1,0,0,0,0,0,0,0,0));
    v.lsudone = 1;
    cycle("lsu_c3", v, 1'b1, 1, mk(0,1,0,1,0,0,0,0,0,0,1));

    // WFI, wake in cycle 4, next instruction decoded in cycle 5.
    v = '0; v.valid = 1; v.wfi = 1;
    cycle("wfi_c1", v, 1'b1, 1, mk(1,1,0,0,0,0,0,0,0,0,1));
    v = '0; v.valid = 1;
    cycle("wfi_c2", v, 1'b1, 1, mk(0,0,1,0,0,0,0,0,0,0,0));
    cycle("wfi_c3", v, 1'b1, 1, mk(0,0,1,0,0,0,0,0,0,0,0));
    v.irq = 1;
    cycle("wfi_c4", v, 1'b1, 1, mk(0,0,1,0,0,0,0,0,0,0,0));
    v.irq = 0;
    cycle("wfi_c5", v, 1'b1, 1, mk(1,1,0,1,0,0,0,0,0,0,1));

    // Counter wrap from all-ones.
    v = '0; v.valid = 1;
    cycle("wrap_rst", v, 1'b0, 1, z);
    for (int c = 0; c < 15; c++) cycle("wrap_fill", v, 1'b1, 1, mk(1,1,0,1,0,0,0,0,0,0,1));
    chk_cnt("wrap_full", 4'hF);
    cycle("wrap_ret", v, 1'b1, 1, mk(1,1,0,1,0,0,0,0,0,0,1));
    chk_cnt("wrap_zero", 0);

    // Random traffic against the model, including occasional mid-instruction resets.
    for (int i = 0; i < 2000; i++) begin
      in_t r;
      r.valid   = ($urandom_range(3) != 0);
      r.illegal = ($urandom_range(15) == 0);
      r.ecall   = ($urandom_range(15) == 0);
      r.ebrk    = ($urandom_range(15) == 0);
      r.mret    = ($urandom_range(15) == 0);
      r.wfi     = ($urandom_range(15) == 0);
      r.jump    = ($urandom_range(9) == 0);
      r.branch  = ($urandom_range(6) == 0);
      r.mult    = ($urandom_range(9) == 0);
      r.div     = ($urandom_range(9) == 0);
      r.req     = ($urandom_range(6) == 0);
      r.flush   = ($urandom_range(9) == 0);
      r.taken   = $urandom_range(1);
      r.mdready = ($urandom_range(2) == 0);
      r.lsudone = ($urandom_range(2) == 0);
      r.irq     = ($urandom_range(3) == 0);
      cycle("rand", r, ($urandom_range(49) != 0), 0, z);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ibex_id_sequencer.md
# ibex_id_sequencer

Decode-stage sequencer for the instruction decoder. It holds each fetched instruction in ID until the instruction completes. It drives the decoder's `instr_new_i` and sequences two-cycle jumps and taken branches, multi-cycle mult/div and LSU accesses, traps, `mret`, CSR pipeline flushes and WFI sleep. It also gates register-file writes and maintains a retired-instruction counter.

## Interface
Parameters:
- `MinstretWidth`, default 32: width of the retired-instruction counter.

Ports:
- `clk` in 1: clock, all state on the rising edge.
- `rst_ni` in 1: reset, synchronous, active-low.
- `instr_valid_i` in 1: IF presents an instruction to ID.
- `dec_illegal_i`, `dec_ecall_i`, `dec_ebrk_i`, `dec_mret_i`, `dec_wfi_i` in 1 each: decoder class flags, combinational from the held instruction.
- `dec_jump_set_i`, `dec_branch_in_dec_i`, `dec_mult_en_i`, `dec_div_en_i`, `dec_data_req_i`, `dec_csr_pipe_flush_i` in 1 each: decoder control flags.
- `branch_taken_i` in 1: ALU comparison result, valid in the branch's first cycle.
- `md_ready_i` in 1: mult/div result available this cycle.
- `lsu_done_i` in 1: LSU access completes this cycle.
- `irq_pending_i` in 1: enabled interrupt pending (WFI wake).
- `instr_new_o` out 1: to decoder `instr_new_i`; high in the first cycle of each instruction.
- `instr_ack_o` out 1: ID consumes the instruction this cycle, so IF may advance.
- `halt_if_o` out 1: high when `instr_valid_i` is high and `instr_ack_o` is low, or when in SLEEP.
- `regfile_we_en_o` out 1: gate ANDed with the decoder's `regfile_we_o`.
- `md_en_o` out 1: mult/div enable.
- `lsu_req_o` out 1: single-cycle LSU request pulse.
- `pc_set_o` out 1: redirect fetch.
- `pc_mux_o` out 2: redirect source. 0 = jump/branch target (ALU result), 1 = exception vector, 2 = mepc (mret), 3 = PC+4 (flush).
- `exc_req_o` out 1: trap request pulse.
- `exc_cause_o` out 2: 0 illegal, 1 ecall, 2 ebreak.
- `instr_ret_o` out 1: retire pulse.
- `minstret_o` out `MinstretWidth`: retired-instruction count.

## Operation
States: DECODE, SECOND, MD_WAIT, LSU_WAIT, SLEEP. The state resets to DECODE.

DECODE with `instr_valid_i` high: `instr_new_o`=1. Decoder flags are evaluated in this priority order:
1. `dec_illegal_i` > `dec_ebrk_i` > `dec_ecall_i`: `exc_req_o`=1 with cause, `pc_set_o`=1, `pc_mux_o`=1, ack. `regfile_we_en_o`=0 and no retire. Stay in DECODE.
2. `dec_mret_i`: `pc_set_o`=1, `pc_mux_o`=2, ack, retire.
3. `dec_wfi_i`: ack, retire, go to SLEEP.
4. `dec_jump_set_i`: `pc_set_o`=1, `pc_mux_o`=0, `regfile_we_en_o`=0, go to SECOND.
5. `dec_branch_in_dec_i`:
   - taken: go to SECOND.
   - not taken: ack, retire, stay.
6. `dec_mult_en_i` or `dec_div_en_i`: `md_en_o`=1.
   - `md_ready_i` high in the same cycle: ack, `regfile_we_en_o`=1, retire.
   - otherwise: go to MD_WAIT.
7. `dec_data_req_i`: `lsu_req_o`=1, `regfile_we_en_o`=0, go to LSU_WAIT.
8. `dec_csr_pipe_flush_i`: `regfile_we_en_o`=1, `pc_set_o`=1, `pc_mux_o`=3, ack, retire.
9. Otherwise: `regfile_we_en_o`=1, ack, retire.

SECOND: `instr_new_o`=0, ack, retire, then DECODE.
- Jump: `regfile_we_en_o`=1 (link write).
- Branch: `pc_set_o`=1, `pc_mux_o`=0, `regfile_we_en_o`=0.

MD_WAIT: `md_en_o` held at 1. On `md_ready_i`: ack, `regfile_we_en_o`=1, retire, then DECODE.

LSU_WAIT: `lsu_req_o`=0. On `lsu_done_i`: ack, `regfile_we_en_o`=1, retire, then DECODE.

SLEEP: `halt_if_o`=1 and `instr_valid_i` is ignored. On `irq_pending_i`, go to DECODE next cycle.

Any `instr_valid_i` activity outside DECODE does not start a new instruction.

`minstret_o` increments by 1 on each `instr_ret_o` and wraps from all-ones to 0.

## Timing
- Reset, synchronous on `rst_ni`=0 at an edge: state DECODE, `minstret_o`=0. All combinational outputs read 0 while in reset. A reset mid-operation aborts any SECOND, MD_WAIT, LSU_WAIT or SLEEP.
- All outputs other than `minstret_o` are combinational from state and inputs. `minstret_o` is registered, so it updates the cycle after `instr_ret_o`.
- Latencies:
  - ALU, CSR, trap, mret, not-taken branch: 1 cycle.
  - Jump, taken branch: 2 cycles.
  - Mult/div: 1 + cycles until `md_ready_i`.
  - Load/store: 1 + cycles until `lsu_done_i`; a `lsu_done_i` high in the DECODE request cycle is ignored.
- `instr_ack_o`, `instr_ret_o`, `exc_req_o`, `pc_set_o` and `lsu_req_o` are single-cycle pulses per instruction; at most one `pc_set_o` per instruction.
- `irq_pending_i` already high when WFI acks: SLEEP lasts exactly 1 cycle.

## Test plan
- Reset with `instr_valid_i`=1 and ALU flags → all outputs 0; after release, ack and `regfile_we_en_o`=1 in cycle 1, and `minstret_o`=1 one cycle later.
- JAL: cycle 1 `pc_set_o`=1, `pc_mux_o`=0, `regfile_we_en_o`=0, ack=0. Cycle 2 `instr_new_o`=0, `regfile_we_en_o`=1, ack=1.
- Branch with `branch_taken_i`=0 → ack in cycle 1. With `branch_taken_i`=1 → `pc_set_o` and ack in cycle 2, `regfile_we_en_o`=0 throughout.
- DIV with `md_ready_i` rising in cycle 5 → `md_en_o` high in cycles 1-5, `halt_if_o` high in cycles 1-4, ack and `regfile_we_en_o` in cycle 5 only.
- `dec_illegal_i` and `dec_ecall_i` both high → `exc_cause_o`=0, `pc_mux_o`=1, no retire, `minstret_o` unchanged.
- WFI, then `irq_pending_i` in cycle 4 → `halt_if_o`=1 in cycles 2-4, DECODE in cycle 5. With `minstret_o`=all-ones, one retire → 0.
